// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - handshaked data-memory load/store access stage
//
// Purpose: runs each load/store from the controller as one transaction on a
// word-wide bus. Generates byte enables and lane-replicated store data,
// extracts and extends load data, rejects misaligned requests and stalls the
// core until the access completes or times out.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   req                 access request, held high while stall=1
//   MemWrite, MemRead   store / load (MemWrite wins if both)
//   memOp               00 word, 01 half, 10 byte, 11 word
//   sext                sign-extend sub-word loads when 1
//   addr, wdata         byte address and store data
//   stall               freeze PC/pipeline
//   rdata               registered, extended load result
//   done                one-cycle pulse when an access finishes
//   misalign            one-cycle pulse when a misaligned request is rejected
//   bus_err             one-cycle pulse with done on timeout abort
//   bus_valid, bus_we   bus request and write strobe
//   bus_be              byte enables, bit i = lane i
//   bus_addr, bus_wdata word address and lane-replicated store data
//   bus_ready           memory completes in the cycle it is sampled
//   bus_rdata           read word, valid with bus_ready

module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  memOp,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t state, state_n;

  logic [31:0]   addr_q;
  logic [1:0]    op_q;
  logic          sext_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt;
  logic          err_q;

  // Request decode (combinational, IDLE-cycle inputs)
  logic        is_half, is_byte, is_word;
  logic        access, mis, accept;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  always_comb begin
    is_half = (memOp == 2'b01);
    is_byte = (memOp == 2'b10);
    is_word = !is_half && !is_byte;
    access  = req && (MemRead || MemWrite);
    mis     = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

    be_in    = 4'b1111;
    wdata_in = wdata;
    if (is_half) begin
      be_in    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{wdata[15:0]}};
    end else if (is_byte) begin
      be_in    = 4'b0001 << addr[1:0];
      wdata_in = {4{wdata[7:0]}};
    end
  end

  // Load data lane selection and extension from the latched request
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (op_q)
      2'b01:   load_ext = {{16{sext_q & lane_h[15]}}, lane_h};
      2'b10:   load_ext = {{24{sext_q & lane_b[7]}}, lane_b};
      default: load_ext = bus_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and outputs
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    stall     = 1'b0;
    misalign  = 1'b0;
    done      = 1'b0;
    bus_err   = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_be    = 4'b0000;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;

    case (state)
      IDLE: begin
        // Gated with rst so reset kills the combinational stall/misalign
        // paths immediately even while req is still held high.
        if (access && !rst) begin
          if (mis) begin
            misalign = 1'b1;
          end else begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_be    = be_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_wdata = wdata_q;
        if (bus_ready || (cnt == CNT_LAST)) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        bus_err = err_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Transaction registers, timeout counter and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'h0;
      op_q    <= 2'b00;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata   <= 32'h0;
    end else if (accept) begin
      addr_q  <= addr;
      op_q    <= memOp;
      sext_q  <= sext;
      we_q    <= MemWrite;
      be_q    <= be_in;
      wdata_q <= wdata_in;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else if (state == BUSY) begin
      // A ready in the final allowed cycle still counts as success.
      if (bus_ready) begin
        if (!we_q) rdata <= load_ext;
      end else if (cnt == CNT_LAST) begin
        err_q <= 1'b1;
        if (!we_q) rdata <= 32'h0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table-driven bench for mem_access_unit

module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, MemWrite, MemRead, sext;
  logic [1:0]  memOp;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign, bus_err, bus_valid, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .MemWrite(MemWrite), .MemRead(MemRead),
    .memOp(memOp), .sext(sext), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .done(done), .misalign(misalign),
    .bus_err(bus_err), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct {
    bit        we;
    bit        re;
    bit [1:0]  op;
    bit        sx;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] rd_bus;
    int        waits;
    bit        tmo;
    bit        mis;
    bit [3:0]  exp_be;
    bit [31:0] exp_wdata;
    bit [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(int idx, vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    req = 1'b1; MemWrite = v.we; MemRead = v.re; memOp = v.op; sext = v.sx;
    addr = v.a; wdata = v.wd; bus_ready = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    if (v.mis) begin
      chk({p, " misalign"}, misalign, 1'b1);
      chk({p, " mis_stall"}, stall, 1'b0);
      chk({p, " mis_valid"}, bus_valid, 1'b0);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk({p, " mis_after_valid"}, bus_valid, 1'b0);
      chk({p, " mis_after_done"}, done, 1'b0);
      return;
    end
    chk({p, " c0_stall"}, stall, 1'b1);
    chk({p, " c0_valid"}, bus_valid, 1'b0);
    chk({p, " c0_misalign"}, misalign, 1'b0);
    for (int i = 0; i <= v.waits; i++) begin
      @(posedge clk); #1;
      bus_ready = (i == v.waits) && !v.tmo;
      bus_rdata = bus_ready ? v.rd_bus : 32'hBAD0BAD0;
      @(negedge clk);
      chk({p, $sformatf(" b%0d_valid", i)}, bus_valid, 1'b1);
      chk({p, $sformatf(" b%0d_stall", i)}, stall, 1'b1);
      chk({p, $sformatf(" b%0d_done", i)}, done, 1'b0);
      if (i == 0) begin
        chk({p, " be"}, bus_be, v.exp_be);
        chk({p, " addr"}, bus_addr, {v.a[31:2], 2'b00});
        chk({p, " we"}, bus_we, v.we);
        if (v.we) chk({p, " wdata"}, bus_wdata, v.exp_wdata);
      end
    end
    @(posedge clk); #1;
    bus_ready = 1'b1;   // ready outside BUSY must be ignored
    bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk({p, " done"}, done, 1'b1);
    chk({p, " d_stall"}, stall, 1'b0);
    chk({p, " d_valid"}, bus_valid, 1'b0);
    chk({p, " bus_err"}, bus_err, v.tmo);
    chk({p, " rdata"}, rdata, v.exp_rdata);
    bus_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we re op     sx a             wd             rd_bus        w  t  m  be       wdata          rdata
    vecs[0]  = '{0, 1, 2'b00, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{0, 1, 2'b10, 1, 32'h13, 32'h0,        32'h80FF0011, 0, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{0, 1, 2'b10, 0, 32'h13, 32'h0,        32'h80FF0011, 0, 0, 0, 4'b1000, 32'h0,        32'h00000080};
    vecs[3]  = '{0, 1, 2'b01, 1, 32'h12, 32'h0,        32'h80FF0011, 0, 0, 0, 4'b1100, 32'h0,        32'hFFFF80FF};
    vecs[4]  = '{1, 0, 2'b10, 0, 32'h21, 32'h123456AB, 32'h0,        3, 0, 0, 4'b0010, 32'hABABABAB, 32'hFFFF80FF};
    vecs[5]  = '{0, 1, 2'b00, 0, 32'h06, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{0, 1, 2'b01, 1, 32'h07, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{0, 1, 2'b01, 0, 32'h10, 32'h0,        32'h1234F678, 0, 0, 0, 4'b0011, 32'h0,        32'h0000F678};
    vecs[8]  = '{1, 1, 2'b01, 0, 32'h16, 32'hAAAA5A5A, 32'h0,        1, 0, 0, 4'b1100, 32'h5A5A5A5A, 32'h0000F678};
    vecs[9]  = '{0, 1, 2'b00, 0, 32'h30, 32'h0,        32'h0,        TMO-1, 1, 0, 4'b1111, 32'h0,  32'h00000000};
    vecs[10] = '{0, 1, 2'b10, 1, 32'h01, 32'h0,        32'h00007F00, 0, 0, 0, 4'b0010, 32'h0,        32'h0000007F};
    vecs[11] = '{0, 1, 2'b11, 1, 32'h08, 32'h0,        32'hCAFEF00D, 0, 0, 0, 4'b1111, 32'h0,        32'hCAFEF00D};
    vecs[12] = '{1, 0, 2'b00, 0, 32'h0C, 32'h11223344, 32'h0,        2, 0, 0, 4'b1111, 32'h11223344, 32'hCAFEF00D};
    vecs[13] = '{0, 1, 2'b10, 0, 32'h02, 32'h0,        32'h00AB0000, 1, 0, 0, 4'b0100, 32'h0,        32'h000000AB};
    vecs[14] = '{1, 0, 2'b10, 0, 32'h40, 32'h000000C3, 32'h0,        TMO-1, 1, 0, 4'b0001, 32'hC3C3C3C3, 32'h000000AB};
    vecs[15] = '{0, 1, 2'b00, 0, 32'h0E, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};

    rst = 1'b1; req = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; memOp = 2'b00;
    sext = 1'b0; addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst stall", stall, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst bus_valid", bus_valid, 1'b0);
    chk("rst bus_be", bus_be, 4'b0000);
    chk("rst bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Ready in IDLE and req without read/write must do nothing
    bus_ready = 1'b1; req = 1'b1;
    @(negedge clk);
    chk("idle_noop stall", stall, 1'b0);
    @(posedge clk); #1;
    bus_ready = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("idle_noop valid", bus_valid, 1'b0);
    chk("idle_noop done", done, 1'b0);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);
    @(posedge clk); #1;
    req = 1'b0;

    // Reset asserted in the second BUSY cycle
    @(posedge clk); #1;
    req = 1'b1; MemWrite = 1'b0; MemRead = 1'b1; memOp = 2'b00; addr = 32'h50;
    bus_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy pre_valid", bus_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstbusy valid", bus_valid, 1'b0);
    chk("rstbusy stall", stall, 1'b0);
    chk("rstbusy rdata", rdata, 32'h0);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstbusy done0", done, 1'b0);
    @(negedge clk);
    chk("rstbusy done1", done, 1'b0);
    chk("rstbusy idle_valid", bus_valid, 1'b0);
    run_vec(100, vecs[0]);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("final idle_valid", bus_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage sitting directly downstream of the main controller: consumes the controller's MemWrite, memOp (word/half/byte) and signed-extension decision together with the ALU-computed address, and runs each load/store as a handshaked transaction on a word-wide data bus. It generates byte enables and store-lane replication, extracts and sign/zero-extends load data, flags misaligned accesses, and stalls the core until the transaction completes or times out.

## Interface
- TIMEOUT, 16: max BUSY cycles waiting for bus_ready before abort (≥1).
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request from current instruction; held high while stall=1.
- MemWrite  in  1  store when 1.
- MemRead  in  1  load when 1; MemWrite has priority if both set.
- memOp  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- sext  in  1  1 sign-extend loads (lb/lh), 0 zero-extend (lbu/lhu); ignored for word.
- addr  in  32  byte address.
- wdata  in  32  store data (low byte/half used for sb/sh).
- stall  out  1  freeze PC/pipeline.
- rdata  out  32  extended load result, registered.
- done  out  1  one-cycle pulse: access finished (ok or error).
- misalign  out  1  one-cycle pulse: misaligned request rejected.
- bus_err  out  1  one-cycle pulse (with done): timeout abort.
- bus_valid  out  1  transaction request to memory.
- bus_we  out  1  write strobe.
- bus_be  out  4  byte enables, bit i = byte lane i (little-endian).
- bus_addr  out  32  {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_ready  in  1  memory accepts/completes in the cycle it is sampled with bus_valid.
- bus_rdata  in  32  read word, valid when bus_ready=1.

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE; all outputs 0, rdata=0.
- IDLE: access = req & (MemRead|MemWrite). Misaligned if half & addr[0], or word & addr[1:0]≠0. Misaligned access: misalign=1 for that cycle, stall=0, no bus activity, stay IDLE. Aligned access: stall=1 combinationally, latch addr/op/sext/we/be/wdata into registers, → BUSY, timeout counter cleared.
- Byte enables: word 1111; half 0011 (addr[1]=0) / 1100 (addr[1]=1); byte 0001<<addr[1:0]. Loads drive the same be.
- bus_wdata: word wdata; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
- BUSY: bus_valid=1, bus_we/be/addr/wdata from registers, stable all of BUSY; stall=1. On bus_ready=1: for load, rdata ← selected lane extended per sext (byte lane addr[1:0], half lane addr[1]); store leaves rdata unchanged; → DONE. Else counter++; when counter reaches TIMEOUT-1 without ready: bus_err=1 next cycle, rdata ← 0 for load, → DONE.
- DONE: stall=0, done=1, bus_valid=0; req ignored (same instruction commits this edge); → IDLE.
- rdata holds last load result until the next load completes.
- Reset asserted mid-BUSY: bus_valid and stall drop immediately (async), state IDLE, no done pulse.

## Timing
- Cycle 0 request accepted (stall=1); cycle 1 first bus_valid cycle; earliest completion with bus_ready=1 in cycle 1 → DONE in cycle 2 with rdata valid. Minimum latency 2 stalled cycles + DONE.
- Wait states: each cycle of bus_ready=0 adds one stalled cycle, up to TIMEOUT BUSY cycles total.
- bus_ready sampled only in BUSY; ready in IDLE/DONE ignored.
- misalign asserted combinationally in the request cycle, no registered side effects.
- Back-to-back accesses: new request accepted earliest in cycle after DONE.

## Test plan
- lw addr=0x10, bus_ready in cycle 1, bus_rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x10, done in cycle 2, rdata=0xDEADBEEF, stall high cycles 0-1.
- lb sext=1 addr=0x13, rdata bus=0x80FF0011 -> be=1000, rdata=0xFFFFFF80; repeat lbu -> 0x00000080; lh addr=0x12 -> be=1100, rdata=0xFFFF80FF.
- sb addr=0x21 wdata=0x123456AB, ready after 3 wait cycles -> bus_we=1, be=0010, bus_wdata=0xABABABAB, stall 5 cycles, rdata unchanged.
- lw addr=0x06 and lh addr=0x07 -> misalign pulse, stall=0, bus_valid never asserts.
- TIMEOUT=4, bus_ready held 0 -> 4 BUSY cycles then DONE with bus_err=1, done=1, rdata=0.
- rst asserted in 2nd BUSY cycle -> bus_valid=0, stall=0 immediately; after release, lw completes normally.
